// File: rtl/similarity_frame_accumulator_if.sv
// similarity_frame_accumulator_if: word-in / frame-result-out handshake bundle.
// Macro SIM_ACC_THRESHOLD_EN adds threshold and match_out.
interface similarity_frame_accumulator_if #(
  parameter int N     = 8,
  parameter int ACC_W = 16
);
  logic [N-1:0]     dist_in;
  logic             dist_valid;
  logic             dist_last;
  logic             dist_ready;
  logic [ACC_W-1:0] sum_out;
  logic [N-1:0]     max_out;
  logic [7:0]       words_out;
  logic             sat_out;
  logic             res_valid;
  logic             res_ready;
`ifdef SIM_ACC_THRESHOLD_EN
  logic [ACC_W-1:0] threshold;
  logic             match_out;
  modport master (output dist_in, dist_valid, dist_last, res_ready, threshold,
                  input dist_ready, sum_out, max_out, words_out, sat_out, res_valid, match_out);
  modport slave  (input dist_in, dist_valid, dist_last, res_ready, threshold,
                  output dist_ready, sum_out, max_out, words_out, sat_out, res_valid, match_out);
`else
  modport master (output dist_in, dist_valid, dist_last, res_ready,
                  input dist_ready, sum_out, max_out, words_out, sat_out, res_valid);
  modport slave  (input dist_in, dist_valid, dist_last, res_ready,
                  output dist_ready, sum_out, max_out, words_out, sat_out, res_valid);
`endif
endinterface

// File: rtl/similarity_frame_accumulator.sv
// similarity_frame_accumulator: saturating per-frame sum/max/count of word distances.
// Macro SIM_ACC_THRESHOLD_EN adds a registered sum <= threshold match flag.
module similarity_frame_accumulator #(
  parameter int N         = 8,
  parameter int FRAME_LEN = 4,
  parameter int ACC_W     = 16
) (
  input logic                          clk,
  input logic                          reset,
  similarity_frame_accumulator_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, ACCUM = 2'd1, HOLD = 2'd2;
  logic [1:0]       state;
  logic [ACC_W-1:0] sum, sum_nx;
  logic [ACC_W:0]   wide;
  logic [N-1:0]     mx, mx_nx;
  logic [7:0]       words, words_nx;
  logic             sat, sat_nx, first, accept, done;
  always_comb begin
    first    = state == IDLE;
    accept   = bus.dist_valid && state != HOLD;
    wide     = (first ? '0 : {1'b0, sum}) + (ACC_W+1)'(bus.dist_in);
    sum_nx   = wide[ACC_W] ? '1 : wide[ACC_W-1:0];
    sat_nx   = wide[ACC_W] || (!first && sat);
    mx_nx    = (first || bus.dist_in > mx) ? bus.dist_in : mx;
    words_nx = first ? 8'd1 : words + 8'd1;
    done     = bus.dist_last || words_nx == 8'(FRAME_LEN);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      sum   <= '0;
      mx    <= '0;
      words <= '0;
      sat   <= 1'b0;
    end else if (accept) begin
      state <= done ? HOLD : ACCUM;
      sum   <= sum_nx;
      mx    <= mx_nx;
      words <= words_nx;
      sat   <= sat_nx;
    end else if (state == HOLD && bus.res_ready) begin
      state <= IDLE;
    end
  end
  assign bus.dist_ready = state != HOLD;
  assign bus.res_valid  = state == HOLD;
  assign bus.sum_out    = sum;
  assign bus.max_out    = mx;
  assign bus.words_out  = words;
  assign bus.sat_out    = sat;
`ifdef SIM_ACC_THRESHOLD_EN
  logic match;
  // Compare the clamped sum so saturation reads as the all-ones value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) match <= 1'b0;
    else if (accept) match <= sum_nx <= bus.threshold;
  end
  assign bus.match_out = match;
`endif
endmodule

// File: tb/tb_similarity_frame_accumulator.sv
// tb_similarity_frame_accumulator: table-driven frames on a 16-bit and an 8-bit accumulator,
// plus hand sequences for HOLD back-pressure and mid-frame reset.
module tb_similarity_frame_accumulator;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   passed = 0;
  int   total = 0;
  always #5 clk = ~clk;
  similarity_frame_accumulator_if #(.N(8), .ACC_W(16)) b ();
  similarity_frame_accumulator_if #(.N(8), .ACC_W(8))  s ();
  similarity_frame_accumulator #(.N(8), .FRAME_LEN(4), .ACC_W(16)) dut (.clk(clk), .reset(reset), .bus(b));
  similarity_frame_accumulator #(.N(8), .FRAME_LEN(4), .ACC_W(8))  dut_s (.clk(clk), .reset(reset), .bus(s));

  typedef struct {
    bit         sel;
    int         n;
    logic [7:0] d [4];
    bit         last;
    int         sum;
    int         mx;
    int         words;
    int         sat;
    int         m;
  } vec_t;
  vec_t vt [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic put(input bit sel, input logic [7:0] d, input bit l);
    int n = 0;
    @(negedge clk);
    if (sel) begin s.dist_in = d; s.dist_valid = 1'b1; s.dist_last = l; end
    else begin b.dist_in = d; b.dist_valid = 1'b1; b.dist_last = l; end
    while (!(sel ? s.dist_ready : b.dist_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("ready_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1;
    s.dist_valid = 1'b0; s.dist_last = 1'b0;
    b.dist_valid = 1'b0; b.dist_last = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_dist_ready"}, 32'(b.dist_ready), 32'd1);
    chk({tag, "_res_valid"}, 32'(b.res_valid), 32'd0);
    chk({tag, "_sum"}, 32'(b.sum_out), 32'd0);
    chk({tag, "_max"}, 32'(b.max_out), 32'd0);
    chk({tag, "_words"}, 32'(b.words_out), 32'd0);
    chk({tag, "_sat"}, 32'(b.sat_out), 32'd0);
`ifdef SIM_ACC_THRESHOLD_EN
    chk({tag, "_match"}, 32'(b.match_out), 32'd0);
`endif
  endtask

  initial begin
    vt[0]  = '{0, 4, '{3, 0, 5, 1},     0, 9,    5,   4, 0, 0};
    vt[1]  = '{0, 4, '{3, 0, 5, 0},     0, 8,    5,   4, 0, 1};
    vt[2]  = '{0, 2, '{2, 7, 0, 0},     1, 9,    7,   2, 0, 0};
    vt[3]  = '{0, 1, '{6, 0, 0, 0},     1, 6,    6,   1, 0, 1};
    vt[4]  = '{0, 4, '{255, 255, 255, 255}, 0, 1020, 255, 4, 0, 0};
    vt[5]  = '{0, 4, '{0, 0, 0, 0},     0, 0,    0,   4, 0, 1};
    vt[6]  = '{0, 3, '{9, 4, 9, 0},     1, 22,   9,   3, 0, 0};
    vt[7]  = '{1, 2, '{200, 100, 0, 0}, 1, 255,  200, 2, 1, 1};
    vt[8]  = '{1, 1, '{4, 0, 0, 0},     1, 4,    4,   1, 0, 1};
    vt[9]  = '{1, 3, '{100, 100, 55, 0}, 1, 255, 100, 3, 0, 1};
    vt[10] = '{1, 3, '{200, 100, 4, 0}, 1, 255,  200, 3, 1, 1};
    b.dist_in = '0; b.dist_valid = 1'b0; b.dist_last = 1'b0; b.res_ready = 1'b1;
    s.dist_in = '0; s.dist_valid = 1'b0; s.dist_last = 1'b0; s.res_ready = 1'b1;
`ifdef SIM_ACC_THRESHOLD_EN
    b.threshold = 16'd8;
    s.threshold = 8'd255;
`endif
    #1;
    check_zero("reset");
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 11; i++) begin
      for (int j = 0; j < vt[i].n; j++) put(vt[i].sel, vt[i].d[j], vt[i].last && j == vt[i].n - 1);
      chk($sformatf("v%0d_res_valid", i), 32'(vt[i].sel ? s.res_valid : b.res_valid), 32'd1);
      chk($sformatf("v%0d_dist_ready_low", i), 32'(vt[i].sel ? s.dist_ready : b.dist_ready), 32'd0);
      chk($sformatf("v%0d_sum", i), vt[i].sel ? 32'(s.sum_out) : 32'(b.sum_out), 32'(vt[i].sum));
      chk($sformatf("v%0d_max", i), 32'(vt[i].sel ? s.max_out : b.max_out), 32'(vt[i].mx));
      chk($sformatf("v%0d_words", i), 32'(vt[i].sel ? s.words_out : b.words_out), 32'(vt[i].words));
      chk($sformatf("v%0d_sat", i), 32'(vt[i].sel ? s.sat_out : b.sat_out), 32'(vt[i].sat));
`ifdef SIM_ACC_THRESHOLD_EN
      chk($sformatf("v%0d_match", i), 32'(vt[i].sel ? s.match_out : b.match_out), 32'(vt[i].m));
`endif
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_ready_back", i), 32'(vt[i].sel ? s.dist_ready : b.dist_ready), 32'd1);
      chk($sformatf("v%0d_valid_drop", i), 32'(vt[i].sel ? s.res_valid : b.res_valid), 32'd0);
    end
    b.res_ready = 1'b0;
    for (int j = 1; j <= 4; j++) put(0, 8'(j), 1'b0);
    @(negedge clk);
    b.dist_in = 8'd50; b.dist_valid = 1'b1; b.dist_last = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("hold%0d_ready", k), 32'(b.dist_ready), 32'd0);
      chk($sformatf("hold%0d_valid", k), 32'(b.res_valid), 32'd1);
      chk($sformatf("hold%0d_sum", k), 32'(b.sum_out), 32'd10);
      chk($sformatf("hold%0d_words", k), 32'(b.words_out), 32'd4);
      @(negedge clk);
    end
    b.res_ready = 1'b1;
    put(0, 8'd50, 1'b1);
    chk("resume_valid", 32'(b.res_valid), 32'd1);
    chk("resume_sum", 32'(b.sum_out), 32'd50);
    chk("resume_words", 32'(b.words_out), 32'd1);
    chk("resume_max", 32'(b.max_out), 32'd50);
    @(posedge clk);
    put(0, 8'd7, 1'b0);
    put(0, 8'd7, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check_zero("midreset");
    @(negedge clk);
    reset = 1'b1;
    for (int j = 0; j < 4; j++) put(0, 8'd1, 1'b0);
    chk("post_reset_valid", 32'(b.res_valid), 32'd1);
    chk("post_reset_sum", 32'(b.sum_out), 32'd4);
    chk("post_reset_words", 32'(b.words_out), 32'd4);
    chk("post_reset_max", 32'(b.max_out), 32'd1);
    @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/similarity_frame_accumulator.md
# similarity_frame_accumulator

Sequential stage directly downstream of the combinational similarity (Hamming-distance) block. It consumes one per-word distance value per accepted transfer, accumulates a frame of up to FRAME_LEN words, and tracks the worst-case word distance and word count. It presents the frame result to the next stage through a valid/ready handshake. Input and output handshakes are decoupled by a three-state controller.

## Interface
Parameters:
- N, 8: width of incoming distance value (matches similarity block output width)
- FRAME_LEN, 4: maximum words per frame (1..255)
- ACC_W, 16: accumulator width, ACC_W >= N

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low; clears all state
- dist_in  input  N  distance of current word pair
- dist_valid  input  1  dist_in valid
- dist_last  input  1  current word closes the frame early; sampled only on accept
- dist_ready  output  1  stage can accept a word
- sum_out  output  ACC_W  accumulated frame distance
- max_out  output  N  largest single-word distance in frame
- words_out  output  8  words in frame (1..FRAME_LEN)
- sat_out  output  1  accumulator saturated during frame
- res_valid  output  1  frame result valid
- res_ready  input  1  downstream accepts result
- threshold  input  ACC_W  match threshold (SIM_ACC_THRESHOLD_EN only)
- match_out  output  1  sum_out <= threshold (SIM_ACC_THRESHOLD_EN only)

## Operation
- Word accept = dist_valid && dist_ready; result accept = res_valid && res_ready.
- States:
  - IDLE: dist_ready=1, res_valid=0.
  - ACCUM: dist_ready=1, res_valid=0.
  - HOLD: dist_ready=0, res_valid=1.
- IDLE, on accept: sum=dist_in (zero-extended), max=dist_in, words=1, sat=0. Go to HOLD if dist_last or FRAME_LEN==1; else ACCUM.
- ACCUM, on accept: sum=sum+dist_in, max=max(max,dist_in), words+1. Go to HOLD if dist_last or words+1==FRAME_LEN.
- HOLD: outputs stable while res_valid=1. On result accept go to IDLE; registers keep last values until the next frame's first word.
- Saturating add: if the sum exceeds 2^ACC_W-1, sum=2^ACC_W-1 and sat=1. sat stays set until the next frame starts.
- No accept while dist_valid=0: state and registers unchanged.
- dist_in and dist_last are ignored in HOLD (dist_ready=0). Upstream holds its word.

## Timing
- All outputs registered. Reset values: dist_ready=1, res_valid=0, sum_out=0, max_out=0, words_out=0, sat_out=0, match_out=0; state IDLE.
- Latency: res_valid rises the cycle after the frame's final word accept.
- Throughput: one word per cycle in IDLE/ACCUM. Each frame costs at least one HOLD cycle, so maximum throughput is FRAME_LEN words per FRAME_LEN+1 cycles.
- res_ready may be high before res_valid. The result is then accepted in the first HOLD cycle, and dist_ready returns the following cycle.
- No combinational path from dist_valid or res_ready to any output.
- Reset asserted mid-frame or in HOLD: immediate asynchronous clear, partial frame discarded, no result emitted. Deassertion is synchronised externally.

## Configuration
- SIM_ACC_THRESHOLD_EN defined:
  - Adds the threshold input and match_out.
  - match_out is registered with the final accumulate, so it is valid together with res_valid.
  - match_out=1 iff final sum_out <= threshold; a saturated sum compares as 2^ACC_W-1.
- SIM_ACC_THRESHOLD_EN undefined: the threshold and match_out ports and the compare logic are absent. All other behaviour is identical.

## Test plan
- Reset then frame of 4 words (3,0,5,1), res_ready=1 -> res_valid one cycle after 4th accept; sum_out=9, max_out=5, words_out=4, sat_out=0; dist_ready low exactly one cycle.
- Frame 2,7 with dist_last on word 2 -> result sum_out=9, max_out=7, words_out=2; the next word starts a new frame with sum=its value.
- ACC_W=8, N=8, words 200,100 with last -> sum_out=255, sat_out=1; next frame word 4 alone with last -> sum_out=4, sat_out=0.
- res_ready held low 5 cycles in HOLD while dist_valid=1 -> dist_ready=0 and outputs stable throughout; no word lost; frame resumes after res_ready=1.
- Reset pulsed low after 2 words of a frame -> all outputs zero immediately; then 4 words of 1 -> sum_out=4, words_out=4.
- SIM_ACC_THRESHOLD_EN, threshold=8: frame 3,0,5,0 -> match_out=1; frame 3,0,5,1 -> match_out=0.
